// File: rtl/hazard_if.sv
// hazard_if: pipeline-to-hazard-unit signal bundle; master is the pipeline, slave is the hazard unit.
interface hazard_if #(
  parameter int AW = 5,
  parameter int TW = 2,
  parameter int CNT_W = 16
);
  logic [TW-1:0] Tuse_rs, Tuse_rt, E_Tnew, M_Tnew;
  logic E_RegWrite, M_RegWrite, W_RegWrite;
  logic [AW-1:0] D_A1, D_A2, E_A1, E_A2, E_A3, M_A2, M_A3, W_A3;
  logic D_md_use, E_md_start, E_md_op, stall_cnt_clr;
  logic stall, md_busy, DM_Fwd;
  logic [1:0] cmp1_Fwd, cmp2_Fwd, ALUa_Fwd, ALUb_Fwd;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output Tuse_rs, Tuse_rt, E_Tnew, M_Tnew, E_RegWrite, M_RegWrite, W_RegWrite,
           D_A1, D_A2, E_A1, E_A2, E_A3, M_A2, M_A3, W_A3,
           D_md_use, E_md_start, E_md_op, stall_cnt_clr,
    input  stall, md_busy, cmp1_Fwd, cmp2_Fwd, ALUa_Fwd, ALUb_Fwd, DM_Fwd, stall_cnt
  );
  modport slave (
    input  Tuse_rs, Tuse_rt, E_Tnew, M_Tnew, E_RegWrite, M_RegWrite, W_RegWrite,
           D_A1, D_A2, E_A1, E_A2, E_A3, M_A2, M_A3, W_A3,
           D_md_use, E_md_start, E_md_op, stall_cnt_clr,
    output stall, md_busy, cmp1_Fwd, cmp2_Fwd, ALUa_Fwd, ALUb_Fwd, DM_Fwd, stall_cnt
  );
endinterface

// File: rtl/hazard_unit_md.sv
// hazard_unit_md: Tuse/Tnew stall and forwarding control, mult/div busy tracking, saturating stall counter.
module hazard_unit_md #(
  parameter int AW = 5,
  parameter int TW = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_if.slave h
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int MW = $clog2(MAXC + 1);
  logic [MW-1:0] md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic stall_rs, stall_rt, md_busy, stall, dm;
  logic [1:0] cmp1, cmp2, alua, alub;
  function automatic logic hit(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic we);
    return we && s == d && s != '0;
  endfunction
  always_comb begin
    stall_rs = (hit(h.D_A1, h.E_A3, h.E_RegWrite) && h.E_Tnew > h.Tuse_rs) ||
               (hit(h.D_A1, h.M_A3, h.M_RegWrite) && h.M_Tnew > h.Tuse_rs);
    stall_rt = (hit(h.D_A2, h.E_A3, h.E_RegWrite) && h.E_Tnew > h.Tuse_rt) ||
               (hit(h.D_A2, h.M_A3, h.M_RegWrite) && h.M_Tnew > h.Tuse_rt);
    md_busy = h.E_md_start || md_cnt_q != '0;
    stall = stall_rs || stall_rt || (h.D_md_use && md_busy);
    cmp1 = (hit(h.D_A1, h.E_A3, h.E_RegWrite) && h.E_Tnew == TW'(0)) ? 2'b10 :
           (hit(h.D_A1, h.M_A3, h.M_RegWrite) && h.M_Tnew == TW'(0)) ? 2'b01 : 2'b00;
    cmp2 = (hit(h.D_A2, h.E_A3, h.E_RegWrite) && h.E_Tnew == TW'(0)) ? 2'b10 :
           (hit(h.D_A2, h.M_A3, h.M_RegWrite) && h.M_Tnew == TW'(0)) ? 2'b01 : 2'b00;
    alua = (hit(h.E_A1, h.M_A3, h.M_RegWrite) && h.M_Tnew == TW'(0)) ? 2'b10 :
           hit(h.E_A1, h.W_A3, h.W_RegWrite) ? 2'b01 : 2'b00;
    alub = (hit(h.E_A2, h.M_A3, h.M_RegWrite) && h.M_Tnew == TW'(0)) ? 2'b10 :
           hit(h.E_A2, h.W_A3, h.W_RegWrite) ? 2'b01 : 2'b00;
    dm = hit(h.M_A2, h.W_A3, h.W_RegWrite);
    // a new start always reloads, so a later op overrides one still in flight
    md_cnt_d = h.E_md_start ? (h.E_md_op ? MW'(DIV_CYCLES) : MW'(MULT_CYCLES)) :
               md_cnt_q != '0 ? md_cnt_q - MW'(1) : md_cnt_q;
    stall_cnt_d = h.stall_cnt_clr ? '0 :
                  (stall && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end
  always_comb begin
    h.stall = rst_n && stall;
    h.md_busy = rst_n && md_busy;
    h.cmp1_Fwd = rst_n ? cmp1 : 2'b00;
    h.cmp2_Fwd = rst_n ? cmp2 : 2'b00;
    h.ALUa_Fwd = rst_n ? alua : 2'b00;
    h.ALUb_Fwd = rst_n ? alub : 2'b00;
    h.DM_Fwd = rst_n && dm;
    h.stall_cnt = stall_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_unit_md.sv
// tb_hazard_unit_md: directed vectors for stall, forwarding, mult/div busy, stall counter and async reset.
module tb_hazard_unit_md;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_pass = 0;
  hazard_if #(.AW(5), .TW(2), .CNT_W(4)) h ();
  hazard_unit_md #(.AW(5), .TW(2), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .h(h)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask
  task automatic clr_in();
    h.Tuse_rs = '0; h.Tuse_rt = '0; h.E_Tnew = '0; h.M_Tnew = '0;
    h.E_RegWrite = 0; h.M_RegWrite = 0; h.W_RegWrite = 0;
    h.D_A1 = '0; h.D_A2 = '0; h.E_A1 = '0; h.E_A2 = '0; h.E_A3 = '0;
    h.M_A2 = '0; h.M_A3 = '0; h.W_A3 = '0;
    h.D_md_use = 0; h.E_md_start = 0; h.E_md_op = 0; h.stall_cnt_clr = 0;
  endtask
  task automatic md_run(input logic op, input int n, input string tag);
    @(negedge clk);
    clr_in();
    h.D_md_use = 1; h.E_md_start = 1; h.E_md_op = op;
    #1 chk({tag, "_t"}, h.stall, 1);
    @(negedge clk);
    h.E_md_start = 0;
    for (int k = 1; k <= n; k++) begin
      #1 chk($sformatf("%s_t+%0d", tag, k), h.stall, 1);
      @(negedge clk);
    end
    #1 chk({tag, "_end_stall"}, h.stall, 0);
    chk({tag, "_end_busy"}, h.md_busy, 0);
  endtask
  initial begin
    rst_n = 0;
    clr_in();
    h.E_md_start = 1;
    h.D_md_use = 1;
    #2 chk("rst_busy", h.md_busy, 0);
    chk("rst_stall", h.stall, 0);
    chk("rst_cnt", h.stall_cnt, 0);
    @(negedge clk);
    clr_in();
    rst_n = 1;
    // load-use through E
    h.D_A1 = 5; h.E_A3 = 5; h.E_Tnew = 2; h.Tuse_rs = 1; h.E_RegWrite = 1;
    #1 chk("lu_stall", h.stall, 1);
    chk("lu_cmp1", h.cmp1_Fwd, 2'b00);
    h.E_Tnew = 0;
    #1 chk("lu_e0_stall", h.stall, 0);
    chk("lu_e0_cmp1", h.cmp1_Fwd, 2'b10);
    h.D_A1 = 0; h.E_A3 = 0;
    #1 chk("zero_stall", h.stall, 0);
    chk("zero_cmp1", h.cmp1_Fwd, 2'b00);
    // M stage boundary: Tnew > Tuse stalls, equal does not
    clr_in();
    h.D_A2 = 9; h.M_A3 = 9; h.M_RegWrite = 1; h.M_Tnew = 1; h.Tuse_rt = 0;
    #1 chk("m_gt_stall", h.stall, 1);
    h.Tuse_rt = 1;
    #1 chk("m_eq_stall", h.stall, 0);
    chk("m_eq_cmp2", h.cmp2_Fwd, 2'b00);
    h.M_Tnew = 0;
    #1 chk("m0_cmp2", h.cmp2_Fwd, 2'b01);
    // ALU / DM priority
    clr_in();
    h.E_A1 = 7; h.E_A2 = 7; h.M_A3 = 7; h.W_A3 = 7; h.M_A2 = 7;
    h.M_RegWrite = 1; h.W_RegWrite = 1;
    #1 chk("alua_m", h.ALUa_Fwd, 2'b10);
    chk("alub_m", h.ALUb_Fwd, 2'b10);
    chk("dm_w", h.DM_Fwd, 1);
    h.M_RegWrite = 0;
    #1 chk("alua_w", h.ALUa_Fwd, 2'b01);
    chk("alub_w", h.ALUb_Fwd, 2'b01);
    h.W_RegWrite = 0;
    #1 chk("alua_none", h.ALUa_Fwd, 2'b00);
    chk("dm_none", h.DM_Fwd, 0);
    clr_in();
    h.D_A2 = 3; h.E_A3 = 3; h.M_A3 = 3; h.E_RegWrite = 1; h.M_RegWrite = 1;
    #1 chk("cmp2_e", h.cmp2_Fwd, 2'b10);
    chk("cmp2_nostall", h.stall, 0);
    h.E_RegWrite = 0;
    #1 chk("cmp2_m", h.cmp2_Fwd, 2'b01);
    // mult/div busy windows
    md_run(1'b0, 5, "mult");
    md_run(1'b1, 10, "div");
    // reload: div, then mult three cycles later
    @(negedge clk);
    clr_in();
    h.E_md_start = 1; h.E_md_op = 1;
    @(negedge clk);
    h.E_md_start = 0;
    @(negedge clk);
    @(negedge clk);
    h.E_md_start = 1; h.E_md_op = 0;
    @(negedge clk);
    h.E_md_start = 0;
    for (int k = 1; k <= 5; k++) begin
      #1 chk($sformatf("reload_busy%0d", k), h.md_busy, 1);
      @(negedge clk);
    end
    #1 chk("reload_end", h.md_busy, 0);
    // saturating counter
    @(negedge clk);
    clr_in();
    h.stall_cnt_clr = 1;
    @(negedge clk);
    chk("cnt_clr0", h.stall_cnt, 0);
    h.stall_cnt_clr = 0;
    h.D_A1 = 5; h.E_A3 = 5; h.E_RegWrite = 1; h.E_Tnew = 2;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 3) chk("cnt_3", h.stall_cnt, 3);
    end
    chk("cnt_sat", h.stall_cnt, 15);
    @(negedge clk);
    chk("cnt_hold", h.stall_cnt, 15);
    h.stall_cnt_clr = 1;
    @(negedge clk);
    chk("cnt_clr_prio", h.stall_cnt, 0);
    h.stall_cnt_clr = 0;
    @(negedge clk);
    chk("cnt_after_clr", h.stall_cnt, 1);
    // async reset mid-div
    clr_in();
    h.D_md_use = 1; h.E_md_start = 1; h.E_md_op = 1;
    h.D_A1 = 4; h.E_A3 = 4; h.E_RegWrite = 1;
    @(negedge clk);
    h.E_md_start = 0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("pre_rst_busy", h.md_busy, 1);
    chk("pre_rst_cmp1", h.cmp1_Fwd, 2'b10);
    chk("pre_rst_cnt", h.stall_cnt, 4);
    rst_n = 0;
    #1 chk("arst_busy", h.md_busy, 0);
    chk("arst_stall", h.stall, 0);
    chk("arst_cnt", h.stall_cnt, 0);
    chk("arst_cmp1", h.cmp1_Fwd, 2'b00);
    @(negedge clk);
    rst_n = 1;
    #1 chk("post_rst_busy", h.md_busy, 0);
    chk("post_rst_stall", h.stall, 0);
    @(negedge clk);
    chk("post_rst_cnt", h.stall_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_unit_md.md
# hazard_unit_md

Parametrised hazard control unit for the five-stage pipeline (F/D/E/M/W). It generates the D-stage stall and the D/E/M forwarding selects from generalised Tuse/Tnew comparison with arbitrary-width timing codes. It also tracks a multi-cycle multiply/divide unit with a load/decrement busy counter and stalls HI/LO users while that unit is busy. A saturating stall-cycle counter provides performance visibility. The block sits beside the pipeline registers and drives their enables and the forwarding muxes.

## Interface
- AW, 5: register address width; address 0 is hardwired zero.
- TW, 2: width of Tuse/Tnew codes.
- MULT_CYCLES, 5: busy cycles after a mult/multu start; must be ≥1.
- DIV_CYCLES, 10: busy cycles after a div/divu start; must be ≥1.
- CNT_W, 16: stall counter width.

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Tuse_rs, Tuse_rt  in  TW  D-stage operand use deadlines
- E_Tnew, M_Tnew  in  TW  remaining cycles until result ready, per stage
- E_RegWrite, M_RegWrite, W_RegWrite  in  1  stage writes GPR
- D_A1, D_A2, E_A1, E_A2, E_A3, M_A2, M_A3, W_A3  in  AW  source/destination register numbers
- D_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- E_md_start  in  1  E instruction launches mult (E_md_op=0) or div (E_md_op=1)
- E_md_op  in  1  operation select, sampled with E_md_start
- stall_cnt_clr  in  1  synchronous clear of stall_cnt
- stall  out  1  freeze F/D, bubble into E
- md_busy  out  1  multiply/divide unit occupied
- cmp1_Fwd, cmp2_Fwd  out  2  D comparator select: 10=E, 01=M, 00=RF
- ALUa_Fwd, ALUb_Fwd  out  2  E ALU select: 10=M, 01=W, 00=register
- DM_Fwd  out  1  M store data from W
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Match predicate `hit(src, dst, we)`: `src==dst && src!=0 && we`.
- Data stall: `stall_rs = hit(D_A1,E_A3,E_RegWrite) && E_Tnew>Tuse_rs || hit(D_A1,M_A3,M_RegWrite) && M_Tnew>Tuse_rs`.
  - stall_rt is the same expression over D_A2 and Tuse_rt.
  - All comparisons are unsigned, TW bits wide.
- MD stall: `D_md_use && md_busy`.
- `stall = stall_rs || stall_rt || md_stall`.
- Forwarding: a source is eligible only when it hits and its stage Tnew==0. W_Tnew is 0 by definition.
  - cmp1/cmp2: E has priority over M.
  - ALUa/ALUb: M has priority over W.
  - DM_Fwd: hit(M_A2, W_A3, W_RegWrite).
- MD counter md_cnt, width enough for max(MULT_CYCLES, DIV_CYCLES):
  - Idle state: md_cnt==0. Busy state: md_cnt>0.
  - When E_md_start is high, md_cnt loads MULT_CYCLES or DIV_CYCLES per E_md_op. This reload happens even if md_cnt is already nonzero; the later start wins.
  - Otherwise md_cnt decrements if nonzero.
  - `md_busy = E_md_start || md_cnt!=0`.
- stall_cnt:
  - stall_cnt_clr has priority and sets it to 0.
  - Otherwise it increments when stall=1.
  - It holds at all-ones and never wraps.

## Timing
- Stall and forward selects are combinational from current inputs, valid in the same cycle.
- A start in cycle t makes md_busy high in cycles t..t+N (N = configured cycles). md_busy is low at t+N+1; an mfhi held in D issues then.
- stall_cnt updates on the rising edge after the stalled cycle.
- Reset (rst_n=0, asynchronous):
  - md_cnt=0 and stall_cnt=0 immediately.
  - stall, md_busy, all Fwd outputs are forced 0 while rst_n is low.
  - Deassertion mid-operation resumes from the cleared state; an interrupted mult/div is lost.
- A start and stall_cnt_clr in the same cycle are independent.
- Stall caused by both data and MD in one cycle counts once.

## Test plan
- Load-use stall:
  - Stimulus: E_A3=D_A1=5, E_Tnew=2, Tuse_rs=1, E_RegWrite=1.
  - Required: stall=1, cmp1_Fwd=00.
  - Then set E_Tnew=0 → stall=0, cmp1_Fwd=10.
  - With A1=0 → no stall, no forward.
- Priority:
  - Stimulus: E_A1=M_A3=W_A3=7, M_Tnew=0, both writes high.
  - Required: ALUa_Fwd=10. Drop M_RegWrite → 01.
  - Stimulus: D_A2=E_A3=M_A3=3, both Tnew=0. Required: cmp2_Fwd=10.
- MD busy:
  - Stimulus: E_md_start=1, E_md_op=0 at cycle t; D_md_use=1 throughout.
  - Required: stall=1 for t..t+5, stall=0 at t+6.
  - Repeat with div: low at t+11.
- Reload:
  - Stimulus: div start, then a mult start 3 cycles later.
  - Required: busy ends 5 cycles after the second start.
- Counter:
  - CNT_W=4, hold stall 20 cycles → stall_cnt=15 and holds.
  - Pulse stall_cnt_clr → 0 next edge.
- Async reset:
  - Stimulus: assert rst_n=0 mid-div, between edges.
  - Required: md_busy and stall drop immediately, stall_cnt=0; after release md_busy=0 with no start.
